// File: rtl/div_sequencer.sv
// Divide request sequencer: accepts EXE-stage requests, resolves divide-by-zero and signed overflow locally, launches a multi-cycle engine otherwise.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            CLK,
   input  logic            nrst,
   input  logic            req_valid,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_opA,
   input  logic [XLEN-1:0] req_opB,
   output logic            req_ready,
   input  logic            flush,
   output logic            eng_start,
   output logic            eng_signed,
   output logic [XLEN-1:0] eng_dividend,
   output logic [XLEN-1:0] eng_divisor,
   input  logic            eng_done,
   input  logic [XLEN-1:0] eng_quot,
   input  logic [XLEN-1:0] eng_rem,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ENG, RESP, DRAIN} state_t;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   logic            op_rem;
   logic            accept;
   logic            div_zero;
   logic            overflow;
   logic [XLEN-1:0] special_res;

`ifdef DIV_RESULT_CACHE_EN
   logic            c_valid;
   logic [XLEN-1:0] c_opa;
   logic [XLEN-1:0] c_opb;
   logic            c_unsigned;
   logic [XLEN-1:0] c_quot;
   logic [XLEN-1:0] c_rem;
   logic            cache_hit;

   assign cache_hit = c_valid && (c_opa == req_opA) && (c_opb == req_opB)
                      && (c_unsigned == req_op[0]);
`endif

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready && !flush;
   assign busy      = (state == IDLE) ? (req_valid && !flush) : 1'b1;

   // Same-cycle flush/reset must kill the launch and response pulses, so these gate the state decode.
   assign eng_start  = (state == LAUNCH) && !flush && nrst;
   assign resp_valid = (state == RESP) && !flush && nrst;

   always_comb begin
      div_zero    = (req_opB == '0);
      overflow    = !req_op[0] && (req_opA == INT_MIN) && (req_opB == '1);
      special_res = '0;
      if (div_zero)
         special_res = req_op[1] ? req_opA : '1;
      else if (overflow)
         special_res = req_op[1] ? '0 : INT_MIN;
   end

   always_ff @(posedge CLK) begin
      if (!nrst) begin
         state        <= IDLE;
         op_rem       <= 1'b0;
         resp_data    <= '0;
         eng_signed   <= 1'b0;
         eng_dividend <= '0;
         eng_divisor  <= '0;
`ifdef DIV_RESULT_CACHE_EN
         c_valid      <= 1'b0;
         c_opa        <= '0;
         c_opb        <= '0;
         c_unsigned   <= 1'b0;
         c_quot       <= '0;
         c_rem        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_rem <= req_op[1];
                  if (div_zero || overflow) begin
                     resp_data <= special_res;
                     state     <= RESP;
                  end
`ifdef DIV_RESULT_CACHE_EN
                  else if (cache_hit) begin
                     resp_data <= req_op[1] ? c_rem : c_quot;
                     state     <= RESP;
                  end
`endif
                  else begin
                     eng_dividend <= req_opA;
                     eng_divisor  <= req_opB;
                     eng_signed   <= !req_op[0];
                     state        <= LAUNCH;
                  end
               end
            end
            LAUNCH: state <= flush ? IDLE : WAIT_ENG;
            WAIT_ENG: begin
               if (flush) begin
                  state <= eng_done ? IDLE : DRAIN;
               end else if (eng_done) begin
                  resp_data <= op_rem ? eng_rem : eng_quot;
                  state     <= RESP;
`ifdef DIV_RESULT_CACHE_EN
                  c_valid    <= 1'b1;
                  c_opa      <= eng_dividend;
                  c_opb      <= eng_divisor;
                  c_unsigned <= !eng_signed;
                  c_quot     <= eng_quot;
                  c_rem      <= eng_rem;
`endif
               end
            end
            RESP:  state <= IDLE;
            DRAIN: if (eng_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
